// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {RUN, HALT} fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit, bundled in one interface.
interface instruction_fetch_unit_if;

  logic        IMEM_EN;
  logic [15:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        STALL;
  logic        REDIRECT_EN;
  logic [15:0] REDIRECT_PC;
  logic [31:0] INST_MEM_DATA_BUS;
  logic [15:0] INST_PC;
  logic        INST_VALID;
  logic        MISALIGNED_FAULT;

  modport master (
    output IMEM_EN, IMEM_ADDR, INST_MEM_DATA_BUS, INST_PC, INST_VALID, MISALIGNED_FAULT,
    input  IMEM_RDATA, STALL, REDIRECT_EN, REDIRECT_PC
  );

  modport slave (
    input  IMEM_EN, IMEM_ADDR, INST_MEM_DATA_BUS, INST_PC, INST_VALID, MISALIGNED_FAULT,
    output IMEM_RDATA, STALL, REDIRECT_EN, REDIRECT_PC
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {inst, pc} pairs; flush wins over push/pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    // A push into a full buffer is accepted only when a pop frees the head slot.
    do_push = push_i && ((count_q != 2'd2) || pop_i);
    do_pop  = pop_i && (count_q != 2'd0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) wptr_d = ~wptr_q;
      if (do_pop)  rptr_d = ~rptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, issues word reads, buffers responses and feeds decode,
// handling stalls, redirects and misaligned-target halts.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input logic                       CK_REF,
  input logic                       RST_N,
  instruction_fetch_unit_if.master  fetch_bus
);

  fetch_state_t state_q, state_d;
  logic [15:0]  fpc_q, fpc_d;
  logic [15:0]  issued_pc_q, issued_pc_d;
  logic [15:0]  last_pc_q, last_pc_d;
  logic         inflight_q, inflight_d;
  logic         fault_q, fault_d;

  logic [1:0]   buf_count;
  fetch_entry_t buf_head, push_entry;
  logic         push, pop, flush, issue, inst_valid;
  logic [2:0]   occ_after;

  always_comb begin
    inst_valid  = (state_q == RUN) && (buf_count != 2'd0);
    pop         = inst_valid && !fetch_bus.STALL;
    occ_after   = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    // Issue is gated by reset so the memory sees no strobe while RST_N is held low.
    issue       = RST_N && (state_q == RUN) && !fetch_bus.REDIRECT_EN && (occ_after <= 3'd1);
    state_d     = state_q;
    fpc_d       = fpc_q;
    fault_d     = fault_q;
    push        = 1'b0;
    flush       = 1'b0;
    push_entry  = '{inst: fetch_bus.IMEM_RDATA, pc: issued_pc_q};
    inflight_d  = issue;
    issued_pc_d = issue ? fpc_q : issued_pc_q;
    last_pc_d   = inst_valid ? buf_head.pc : last_pc_q;
    unique case (state_q)
      RUN: begin
        if (fetch_bus.REDIRECT_EN) begin
          flush = 1'b1;
          if (fetch_bus.REDIRECT_PC[1:0] != 2'b00) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            fpc_d = fetch_bus.REDIRECT_PC;
          end
        end else begin
          push = inflight_q;
          if (issue) fpc_d = fpc_q + 16'd4;
        end
      end
      HALT: ;
    endcase
  end

  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      state_q     <= RUN;
      fpc_q       <= RESET_VECTOR;
      issued_pc_q <= RESET_VECTOR;
      last_pc_q   <= 16'h0000;
      inflight_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      issued_pc_q <= issued_pc_d;
      last_pc_q   <= last_pc_d;
      inflight_q  <= inflight_d;
      fault_q     <= fault_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk_i   (CK_REF),
    .rst_ni  (RST_N),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (buf_count),
    .head_o  (buf_head)
  );

  assign fetch_bus.IMEM_EN           = issue;
  assign fetch_bus.IMEM_ADDR         = fpc_q;
  assign fetch_bus.INST_VALID        = inst_valid;
  assign fetch_bus.INST_MEM_DATA_BUS = inst_valid ? buf_head.inst : NOP_INST;
  assign fetch_bus.INST_PC           = inst_valid ? buf_head.pc : last_pc_q;
  assign fetch_bus.MISALIGNED_FAULT  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: expected PCs are queued as stimulus is applied and popped on each consume.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst_a_n, rst_b_n;
  int   n_total, n_bad, b_seen;
  logic mon_a_en, mon_b_en;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic [15:0] e_a, e_b;

  instruction_fetch_unit_if bus_a ();
  instruction_fetch_unit_if bus_b ();

  instruction_fetch_unit #(.RESET_VECTOR(16'h0000)) u_dut_a (
    .CK_REF    (clk),
    .RST_N     (rst_a_n),
    .fetch_bus (bus_a)
  );

  instruction_fetch_unit #(.RESET_VECTOR(16'hFFF8)) u_dut_b (
    .CK_REF    (clk),
    .RST_N     (rst_b_n),
    .fetch_bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: one-cycle latency, garbage when no read was strobed.
  always @(posedge clk) begin
    bus_a.IMEM_RDATA <= bus_a.IMEM_EN ? {16'hA000, bus_a.IMEM_ADDR} : 32'hDEAD_BEEF;
    bus_b.IMEM_RDATA <= bus_b.IMEM_EN ? {16'hA000, bus_b.IMEM_ADDR} : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_a_en) begin
      if (bus_a.INST_VALID && !bus_a.STALL && !bus_a.REDIRECT_EN) begin
        if (exp_a.size() == 0) begin
          check_eq("a_unexpected_valid", 32'(bus_a.INST_VALID), 32'd0);
        end else begin
          e_a = exp_a.pop_front();
          check_eq("a_pc", 32'(bus_a.INST_PC), 32'(e_a));
          check_eq("a_data", bus_a.INST_MEM_DATA_BUS, {16'hA000, e_a});
        end
      end else if (!bus_a.INST_VALID) begin
        check_eq("a_nop", bus_a.INST_MEM_DATA_BUS, NOP_INST);
      end
    end
    if (mon_b_en) begin
      if (bus_b.INST_VALID) begin
        if (exp_b.size() == 0) begin
          check_eq("b_unexpected_valid", 32'(bus_b.INST_VALID), 32'd0);
        end else begin
          e_b = exp_b.pop_front();
          b_seen++;
          check_eq("b_pc", 32'(bus_b.INST_PC), 32'(e_b));
          check_eq("b_data", bus_b.INST_MEM_DATA_BUS, {16'hA000, e_b});
        end
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_a.push_back(start + 16'(4 * i));
  endtask

  task automatic fill_b(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_b.push_back(start + 16'(4 * i));
  endtask

  initial begin
    n_total = 0; n_bad = 0; b_seen = 0;
    mon_a_en = 1'b0; mon_b_en = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.STALL = 1'b0; bus_a.REDIRECT_EN = 1'b0; bus_a.REDIRECT_PC = 16'h0;
    bus_b.STALL = 1'b0; bus_b.REDIRECT_EN = 1'b0; bus_b.REDIRECT_PC = 16'h0;
    to_pos(); to_pos();
    mon_a_en = 1'b1; mon_b_en = 1'b1;

    // Reset state
    to_neg();
    check_eq("rst_en", 32'(bus_a.IMEM_EN), 32'd0);
    check_eq("rst_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    check_eq("rst_data", bus_a.INST_MEM_DATA_BUS, NOP_INST);
    check_eq("rst_pc", 32'(bus_a.INST_PC), 32'h0000);
    check_eq("rst_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("rst_fault", 32'(bus_a.MISALIGNED_FAULT), 32'd0);
    check_eq("rst_b_addr", 32'(bus_b.IMEM_ADDR), 32'hFFF8);
    to_pos();

    // Release and stream
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    fill_a(16'h0000, 16);
    fill_b(16'hFFF8, 100);
    to_neg();
    check_eq("c0_en", 32'(bus_a.IMEM_EN), 32'd1);
    check_eq("c0_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    check_eq("c0_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("b_c0_addr", 32'(bus_b.IMEM_ADDR), 32'hFFF8);
    to_pos();
    to_neg();
    check_eq("c1_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("c1_addr", 32'(bus_a.IMEM_ADDR), 32'h0004);
    check_eq("b_c1_addr", 32'(bus_b.IMEM_ADDR), 32'hFFFC);
    to_pos();
    to_neg();
    check_eq("c2_valid", 32'(bus_a.INST_VALID), 32'd1);
    check_eq("c2_pc", 32'(bus_a.INST_PC), 32'h0000);
    check_eq("b_c2_addr", 32'(bus_b.IMEM_ADDR), 32'h0000);
    check_eq("b_c2_pc", 32'(bus_b.INST_PC), 32'hFFF8);
    to_pos();
    to_neg();
    check_eq("c3_pc", 32'(bus_a.INST_PC), 32'h0004);
    to_pos();

    // Stall five cycles holding PC 0x0008
    bus_a.STALL = 1'b1;
    for (int k = 0; k < 5; k++) begin
      to_neg();
      check_eq("stall_pc", 32'(bus_a.INST_PC), 32'h0008);
      check_eq("stall_valid", 32'(bus_a.INST_VALID), 32'd1);
      check_eq("stall_en", 32'(bus_a.IMEM_EN), 32'd0);
      to_pos();
    end
    bus_a.STALL = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check_eq("rel_valid", 32'(bus_a.INST_VALID), 32'd1);
      check_eq("rel_pc", 32'(bus_a.INST_PC), 32'(16'h0008 + 16'(4 * k)));
      to_pos();
    end

    // Fill buffer under stall, then redirect to 0x0100
    bus_a.STALL = 1'b1;
    to_neg(); to_pos();
    to_neg(); to_pos();
    bus_a.REDIRECT_EN = 1'b1;
    bus_a.REDIRECT_PC = 16'h0100;
    exp_a.delete();
    fill_a(16'h0100, 16);
    to_neg();
    check_eq("red_en", 32'(bus_a.IMEM_EN), 32'd0);
    to_pos();
    bus_a.REDIRECT_EN = 1'b0;
    bus_a.STALL = 1'b0;
    to_neg();
    check_eq("r1_en", 32'(bus_a.IMEM_EN), 32'd1);
    check_eq("r1_addr", 32'(bus_a.IMEM_ADDR), 32'h0100);
    check_eq("r1_valid", 32'(bus_a.INST_VALID), 32'd0);
    to_pos();
    to_neg();
    check_eq("r2_valid", 32'(bus_a.INST_VALID), 32'd0);
    to_pos();
    to_neg();
    check_eq("r3_valid", 32'(bus_a.INST_VALID), 32'd1);
    check_eq("r3_pc", 32'(bus_a.INST_PC), 32'h0100);
    to_pos();
    to_neg(); to_pos();
    to_neg(); to_pos();

    // Misaligned redirect halts until reset
    bus_a.REDIRECT_EN = 1'b1;
    bus_a.REDIRECT_PC = 16'h0102;
    exp_a.delete();
    to_neg(); to_pos();
    bus_a.REDIRECT_EN = 1'b0;
    to_neg();
    check_eq("h_fault", 32'(bus_a.MISALIGNED_FAULT), 32'd1);
    check_eq("h_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("h_en", 32'(bus_a.IMEM_EN), 32'd0);
    check_eq("h_data", bus_a.INST_MEM_DATA_BUS, NOP_INST);
    to_pos();
    bus_a.REDIRECT_EN = 1'b1;
    bus_a.REDIRECT_PC = 16'h0200;
    to_neg();
    check_eq("h2_en", 32'(bus_a.IMEM_EN), 32'd0);
    to_pos();
    bus_a.REDIRECT_EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check_eq("h3_en", 32'(bus_a.IMEM_EN), 32'd0);
      check_eq("h3_valid", 32'(bus_a.INST_VALID), 32'd0);
      check_eq("h3_fault", 32'(bus_a.MISALIGNED_FAULT), 32'd1);
      check_eq("h3_addr_not_target", 32'(bus_a.IMEM_ADDR == 16'h0200), 32'd0);
      to_pos();
    end

    // Reset exits halt
    rst_a_n = 1'b0;
    to_neg(); to_pos();
    to_neg();
    check_eq("x_en", 32'(bus_a.IMEM_EN), 32'd0);
    check_eq("x_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    check_eq("x_data", bus_a.INST_MEM_DATA_BUS, NOP_INST);
    check_eq("x_pc", 32'(bus_a.INST_PC), 32'h0000);
    check_eq("x_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("x_fault", 32'(bus_a.MISALIGNED_FAULT), 32'd0);
    to_pos();

    // One-cycle reset while the first fetch is in flight
    rst_a_n = 1'b1;
    fill_a(16'h0000, 16);
    to_neg();
    check_eq("y_en", 32'(bus_a.IMEM_EN), 32'd1);
    check_eq("y_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    to_pos();
    rst_a_n = 1'b0;
    to_neg();
    check_eq("z_en", 32'(bus_a.IMEM_EN), 32'd0);
    to_pos();
    rst_a_n = 1'b1;
    to_neg();
    check_eq("m_en", 32'(bus_a.IMEM_EN), 32'd1);
    check_eq("m_addr", 32'(bus_a.IMEM_ADDR), 32'h0000);
    check_eq("m_valid", 32'(bus_a.INST_VALID), 32'd0);
    check_eq("m_pc", 32'(bus_a.INST_PC), 32'h0000);
    check_eq("m_fault", 32'(bus_a.MISALIGNED_FAULT), 32'd0);
    to_pos();
    to_neg();
    check_eq("m3_valid", 32'(bus_a.INST_VALID), 32'd0);
    to_pos();
    to_neg();
    check_eq("m4_valid", 32'(bus_a.INST_VALID), 32'd1);
    check_eq("m4_pc", 32'(bus_a.INST_PC), 32'h0000);
    to_pos();
    to_neg(); to_pos();
    to_neg(); to_pos();

    check_eq("b_wrap_seen", 32'(b_seen >= 3), 32'd1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
